// File: rtl/adpll_tdc_pkg.sv
// Shared constants for the TDC thermometer decoder.
//   N_TAPS_DEF : default delay-line tap count
//   ERR_CNT_W  : width of the saturating code-error counter
//   bw_of()    : output code width able to hold 0..n_taps
package adpll_tdc_pkg;

  localparam int N_TAPS_DEF = 64;
  localparam int ERR_CNT_W  = 8;

  function automatic int bw_of(input int n_taps);
    return $clog2(n_taps + 1);
  endfunction

endpackage

// File: rtl/tdc_bubble_fix.sv
// Combinational bubble correction for a TDC thermometer code.
// Each output bit is the 3-input majority of itself and its neighbours.
// Below tap 0 the line is treated as 1, above the last tap as 0, so the
// end taps are corrected consistently with an ideal thermometer.
// Ports:
//   i_therm [N_TAPS] : raw (registered) thermometer code, bit 0 = first tap
//   o_corr  [N_TAPS] : bubble-corrected code
module tdc_bubble_fix #(
  parameter int N_TAPS = 64
) (
  input  logic [N_TAPS-1:0] i_therm,
  output logic [N_TAPS-1:0] o_corr
);

  // w_ext[i+1] = i_therm[i]; w_ext[0] = 1, w_ext[N_TAPS+1] = 0
  logic [N_TAPS+1:0] w_ext;
  assign w_ext = {1'b0, i_therm, 1'b1};

  for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_maj
    assign o_corr[gi] = (w_ext[gi]   & w_ext[gi+1]) |
                        (w_ext[gi]   & w_ext[gi+2]) |
                        (w_ext[gi+1] & w_ext[gi+2]);
  end

endmodule

// File: rtl/tdc_therm_decoder.sv
// Three-stage TDC thermometer-to-binary decoder with running statistics.
//   stage 1 : capture therm_in on sample_en
//   stage 2 : bubble correction (tdc_bubble_fix), registered
//   stage 3 : first-zero search -> dout / code_err, registered with dout_valid
// Statistics (dout_min, dout_max, err_cnt) update on the clock edge that
// ends a dout_valid cycle, using the registered dout/code_err.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   sample_en, therm_in : capture strobe and raw thermometer code
//   stat_clr            : clears min/max trackers and error counter
//   dout, dout_valid    : decoded tap count and its one-cycle qualifier
//   code_err            : corrected code had a 1 above its first 0
//   dout_min, dout_max  : running extremes of dout
//   err_cnt             : saturating count of code_err events
module tdc_therm_decoder
  import adpll_tdc_pkg::*;
#(
  parameter int N_TAPS = N_TAPS_DEF,
  parameter int BW     = bw_of(N_TAPS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_en,
  input  logic [N_TAPS-1:0]    therm_in,
  input  logic                 stat_clr,
  output logic [BW-1:0]        dout,
  output logic                 dout_valid,
  output logic                 code_err,
  output logic [BW-1:0]        dout_min,
  output logic [BW-1:0]        dout_max,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [BW-1:0]        L_N_TAPS  = BW'(N_TAPS);
  localparam logic [ERR_CNT_W-1:0] L_CNT_MAX = '1;

  logic [N_TAPS-1:0]    r_t1;
  logic                 r_v1;
  logic [N_TAPS-1:0]    w_c;
  logic [N_TAPS-1:0]    r_c;
  logic                 r_v2;
  logic [BW-1:0]        w_idx;
  logic                 w_err;
  logic [BW-1:0]        r_dout;
  logic                 r_err;
  logic                 r_valid;
  logic [BW-1:0]        r_min;
  logic [BW-1:0]        r_max;
  logic [ERR_CNT_W-1:0] r_cnt;

  // Stage 1: data register holds when no strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t1 <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= sample_en;
      if (sample_en) r_t1 <= therm_in;
    end
  end

  tdc_bubble_fix #(.N_TAPS(N_TAPS)) u_bubble_fix (
    .i_therm (r_t1),
    .o_corr  (w_c)
  );

  // Stage 2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c  <= '0;
      r_v2 <= 1'b0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) r_c <= w_c;
    end
  end

  // First-zero search; any 1 seen after the first 0 flags a non-clean code
  always_comb begin
    logic w_found;
    w_idx   = L_N_TAPS;
    w_err   = 1'b0;
    w_found = 1'b0;
    for (int i = 0; i < N_TAPS; i++) begin
      if (!w_found && !r_c[i]) begin
        w_idx   = BW'(i);
        w_found = 1'b1;
      end else if (w_found && r_c[i]) begin
        w_err = 1'b1;
      end
    end
  end

  // Stage 3: dout/code_err hold between valid pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout  <= '0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_v2;
      if (r_v2) begin
        r_dout <= w_idx;
        r_err  <= w_err;
      end
    end
  end

  // Statistics; a clear coincident with a valid result restarts the
  // trackers from that result instead of from the empty state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_min <= L_N_TAPS;
      r_max <= '0;
      r_cnt <= '0;
    end else if (stat_clr && r_valid) begin
      r_min <= r_dout;
      r_max <= r_dout;
      r_cnt <= ERR_CNT_W'(r_err);
    end else if (stat_clr) begin
      r_min <= L_N_TAPS;
      r_max <= '0;
      r_cnt <= '0;
    end else if (r_valid) begin
      if (r_dout < r_min) r_min <= r_dout;
      if (r_dout > r_max) r_max <= r_dout;
      if (r_err && (r_cnt != L_CNT_MAX)) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign code_err   = r_err;
  assign dout_min   = r_min;
  assign dout_max   = r_max;
  assign err_cnt    = r_cnt;

endmodule

// File: tb/tb_tdc_therm_decoder.sv
module tb_tdc_therm_decoder;
  import adpll_tdc_pkg::*;

  localparam int N  = 64;
  localparam int BW = 7;

  logic          clk;
  logic          rst_n;
  logic          sample_en;
  logic [N-1:0]  therm_in;
  logic          stat_clr;
  logic [BW-1:0] dout;
  logic          dout_valid;
  logic          code_err;
  logic [BW-1:0] dout_min;
  logic [BW-1:0] dout_max;
  logic [7:0]    err_cnt;

  tdc_therm_decoder #(.N_TAPS(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_en  (sample_en),
    .therm_in   (therm_in),
    .stat_clr   (stat_clr),
    .dout       (dout),
    .dout_valid (dout_valid),
    .code_err   (code_err),
    .dout_min   (dout_min),
    .dout_max   (dout_max),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int valid_cnt = 0;

  always @(negedge clk) if (dout_valid === 1'b1) valid_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic strobe(input logic [N-1:0] v);
    @(negedge clk);
    sample_en = 1'b1;
    therm_in  = v;
    @(negedge clk);
    sample_en = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0] therm;
    int           exp_dout;
    bit           exp_err;
  } vec_t;

  vec_t vecs[10];
  int   m_min, m_max, m_cnt;
  int   vc;

  localparam logic [N-1:0] GAP = 64'h0000_0000_3FF0_03FF;

  initial begin
    vecs[0] = '{64'h0000_0000_00FF_FFFF, 24, 1'b0};
    vecs[1] = '{64'h0000_0000_00FF_FBFF, 24, 1'b0};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b0};
    vecs[3] = '{64'h0000_0000_0000_0000,  0, 1'b0};
    vecs[4] = '{GAP,                     10, 1'b1};
    vecs[5] = '{64'h0000_0000_0000_0001,  1, 1'b0};
    vecs[6] = '{64'h0000_0000_0000_0002,  1, 1'b0};
    vecs[7] = '{64'h8000_0000_0000_0000,  0, 1'b0};
    vecs[8] = '{64'hFFFF_FFFF_FFFF_FFFC,  0, 1'b1};
    vecs[9] = '{64'h0000_0001_FFFF_FFFF, 33, 1'b0};

    rst_n = 1'b0; sample_en = 1'b0; stat_clr = 1'b0; therm_in = '0;
    #12;
    chk("rst_valid", dout_valid, 0);
    chk("rst_dout",  dout, 0);
    chk("rst_err",   code_err, 0);
    chk("rst_min",   dout_min, 64);
    chk("rst_max",   dout_max, 0);
    chk("rst_cnt",   err_cnt, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    m_min = 64; m_max = 0; m_cnt = 0;
    foreach (vecs[k]) begin
      strobe(vecs[k].therm);
      @(posedge clk); #1;
      chk($sformatf("v%0d_early", k), dout_valid, 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", k), dout_valid, 1);
      chk($sformatf("v%0d_dout", k),  dout, vecs[k].exp_dout);
      chk($sformatf("v%0d_err", k),   code_err, vecs[k].exp_err);
      if (vecs[k].exp_dout < m_min) m_min = vecs[k].exp_dout;
      if (vecs[k].exp_dout > m_max) m_max = vecs[k].exp_dout;
      if (vecs[k].exp_err && m_cnt < 255) m_cnt++;
      @(posedge clk); #1;
      chk($sformatf("v%0d_pulse", k), dout_valid, 0);
      chk($sformatf("v%0d_hold", k),  dout, vecs[k].exp_dout);
      chk($sformatf("v%0d_min", k),   dout_min, m_min);
      chk($sformatf("v%0d_max", k),   dout_max, m_max);
      chk($sformatf("v%0d_cnt", k),   err_cnt, m_cnt);
    end

    // 300 back-to-back wide-gap samples: full throughput, counter saturates
    @(negedge clk);
    vc = valid_cnt;
    for (int i = 0; i < 300; i++) begin
      sample_en = 1'b1;
      therm_in  = GAP;
      @(negedge clk);
    end
    sample_en = 1'b0;
    repeat (5) @(negedge clk);
    chk("burst_valids", valid_cnt - vc, 300);
    chk("burst_dout",   dout, 10);
    chk("burst_err",    code_err, 1);
    chk("burst_sat",    err_cnt, 255);
    chk("burst_min",    dout_min, 0);
    chk("burst_max",    dout_max, 64);

    // stat_clr alone
    stat_clr = 1'b1;
    @(negedge clk); stat_clr = 1'b0;
    chk("clr_min", dout_min, 64);
    chk("clr_max", dout_max, 0);
    chk("clr_cnt", err_cnt, 0);

    // stat_clr coincident with dout_valid (dout=33)
    strobe(64'h0000_0001_FFFF_FFFF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("co_valid", dout_valid, 1);
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    chk("co_min", dout_min, 33);
    chk("co_max", dout_max, 33);
    chk("co_cnt", err_cnt, 0);

    // back-to-back 5,6,7 then reset: only 5 emerges
    @(negedge clk); sample_en = 1'b1; therm_in = 64'h1F;
    @(negedge clk); therm_in = 64'h3F;
    @(negedge clk); therm_in = 64'h7F;
    @(negedge clk); sample_en = 1'b0;
    chk("b2b_valid5", dout_valid, 1);
    chk("b2b_dout5",  dout, 5);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", dout_valid, 0);
    chk("arst_dout",  dout, 0);
    chk("arst_err",   code_err, 0);
    chk("arst_min",   dout_min, 64);
    chk("arst_max",   dout_max, 0);
    chk("arst_cnt",   err_cnt, 0);
    @(negedge clk); rst_n = 1'b1;
    vc = valid_cnt;
    repeat (6) @(negedge clk);
    chk("flush_valids", valid_cnt - vc, 0);

    // first post-reset sample
    strobe(64'h7F);
    @(posedge clk); #1;
    chk("post_early", dout_valid, 0);
    @(posedge clk); #1;
    chk("post_valid", dout_valid, 1);
    chk("post_dout",  dout, 7);
    @(posedge clk); #1;
    chk("post_min", dout_min, 7);
    chk("post_max", dout_max, 7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
